// File: rtl/tlul_host_arbiter.sv
// Shares one req/gnt/valid host port between N_HOSTS requesters.
// Round-robin request selection with A-channel lock, plus an in-order
// FIFO of requester IDs that steers each response back to its owner.

package tlul_pkg;
    parameter int TL_AW  = 32;
    parameter int TL_DW  = 32;
    parameter int TL_DBW = TL_DW / 8;
endpackage

module tlul_host_arbiter
    import tlul_pkg::*;
#(
    parameter int N_HOSTS = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_HOSTS-1:0]          h_req_i,
    output logic [N_HOSTS-1:0]          h_gnt_o,
    input  logic [N_HOSTS*TL_AW-1:0]    h_addr_i,
    input  logic [N_HOSTS-1:0]          h_we_i,
    input  logic [N_HOSTS*TL_DW-1:0]    h_wdata_i,
    input  logic [N_HOSTS*TL_DBW-1:0]   h_be_i,
    output logic [N_HOSTS-1:0]          h_valid_o,
    output logic [TL_DW-1:0]            h_rdata_o,
    output logic                        h_err_o,
    output logic                        m_req_o,
    input  logic                        m_gnt_i,
    output logic [TL_AW-1:0]            m_addr_o,
    output logic                        m_we_o,
    output logic [TL_DW-1:0]            m_wdata_o,
    output logic [TL_DBW-1:0]           m_be_o,
    input  logic                        m_valid_i,
    input  logic [TL_DW-1:0]            m_rdata_i,
    input  logic                        m_err_i,
    output logic                        unexp_rsp_o
);

    localparam int ID_W  = $clog2(N_HOSTS);
    localparam int IDX_W = ID_W + 1;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  sel_q;
    logic             lock_q;
    logic [ID_W-1:0]  arb_sel;
    logic [ID_W-1:0]  sel;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [ID_W-1:0]  id_mem [MAX_OUT];
    logic [ID_W-1:0]  head_id;
    logic             full;
    logic             accept;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting at rr_q; iterating backwards lets the
    // nearest requester in search order win.
    always_comb begin
        arb_sel = rr_q;
        idx     = '0;
        for (int k = N_HOSTS - 1; k >= 0; k--) begin
            idx = {1'b0, rr_q} + IDX_W'(k);
            if (idx >= IDX_W'(N_HOSTS)) begin
                idx = idx - IDX_W'(N_HOSTS);
            end
            if (h_req_i[idx[ID_W-1:0]]) begin
                arb_sel = idx[ID_W-1:0];
            end
        end
    end

    // A presented-but-ungranted request keeps its requester until accepted.
    assign sel     = lock_q ? sel_q : arb_sel;
    assign full    = (count_q == CNT_W'(MAX_OUT));
    assign m_req_o = rst_ni && ((|h_req_i) || lock_q) && !full;
    assign accept  = m_req_o && m_gnt_i;
    assign pop     = rst_ni && m_valid_i && (count_q != '0);
    assign head_id = id_mem[rd_ptr_q];

    assign m_addr_o  = h_addr_i[sel*TL_AW +: TL_AW];
    assign m_we_o    = h_we_i[sel];
    assign m_wdata_o = h_wdata_i[sel*TL_DW +: TL_DW];
    assign m_be_o    = h_be_i[sel*TL_DBW +: TL_DBW];

    assign h_rdata_o   = m_rdata_i;
    assign h_err_o     = m_err_i;
    assign unexp_rsp_o = rst_ni && m_valid_i && (count_q == '0);

    generate
        for (genvar gi = 0; gi < N_HOSTS; gi++) begin : g_host
            assign h_gnt_o[gi]   = accept && (sel == ID_W'(gi));
            assign h_valid_o[gi] = pop && (head_id == ID_W'(gi));
        end
    endgenerate

    // Arbitration pointer and lock state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else if (accept) begin
            lock_q <= 1'b0;
            rr_q   <= (sel == ID_W'(N_HOSTS - 1)) ? '0 : sel + 1'b1;
        end else if (m_req_o) begin
            lock_q <= 1'b1;
            sel_q  <= sel;
        end
    end

    // ID FIFO pointers and occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ID storage; entries beyond the read pointer are ignored after reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_mem[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter (N_HOSTS=2, MAX_OUT=2).
module tb_tlul_host_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  h_req_i;
    logic [1:0]  h_gnt_o;
    logic [63:0] h_addr_i;
    logic [1:0]  h_we_i;
    logic [63:0] h_wdata_i;
    logic [7:0]  h_be_i;
    logic [1:0]  h_valid_o;
    logic [31:0] h_rdata_o;
    logic        h_err_o;
    logic        m_req_o;
    logic        m_gnt_i;
    logic [31:0] m_addr_o;
    logic        m_we_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_be_o;
    logic        m_valid_i;
    logic [31:0] m_rdata_i;
    logic        m_err_i;
    logic        unexp_rsp_o;

    int checks = 0;
    int errors = 0;

    tlul_host_arbiter #(.N_HOSTS(2), .MAX_OUT(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h_req_i(h_req_i), .h_gnt_o(h_gnt_o), .h_addr_i(h_addr_i),
        .h_we_i(h_we_i), .h_wdata_i(h_wdata_i), .h_be_i(h_be_i),
        .h_valid_o(h_valid_o), .h_rdata_o(h_rdata_o), .h_err_o(h_err_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o),
        .m_we_o(m_we_o), .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
        .m_valid_i(m_valid_i), .m_rdata_i(m_rdata_i), .m_err_i(m_err_i),
        .unexp_rsp_o(unexp_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_ni    = 1'b0;
        h_req_i   = 2'b11;
        h_addr_i  = '0;
        h_we_i    = '0;
        h_wdata_i = '0;
        h_be_i    = '0;
        m_gnt_i   = 1'b1;
        m_valid_i = 1'b1;
        m_rdata_i = '0;
        m_err_i   = 1'b0;

        // Reset: everything gated even with active inputs
        tick();
        chk("rst_m_req", 32'(m_req_o), 32'h0);
        chk("rst_h_gnt", 32'(h_gnt_o), 32'h0);
        chk("rst_h_valid", 32'(h_valid_o), 32'h0);
        chk("rst_unexp", 32'(unexp_rsp_o), 32'h0);
        tick();
        $display("reset applied");

        // Test 1: single request from host 0, then its response
        rst_ni = 1'b1;
        m_valid_i = 1'b0;
        h_req_i = 2'b01;
        h_addr_i[31:0] = 32'h0000_1000;
        h_we_i[0] = 1'b1;
        h_wdata_i[31:0] = 32'h0000_00A5;
        h_be_i[3:0] = 4'hF;
        m_gnt_i = 1'b1;
        settle();
        chk("t1_m_req", 32'(m_req_o), 32'h1);
        chk("t1_m_addr", m_addr_o, 32'h0000_1000);
        chk("t1_m_we", 32'(m_we_o), 32'h1);
        chk("t1_m_wdata", m_wdata_o, 32'h0000_00A5);
        chk("t1_m_be", 32'(m_be_o), 32'hF);
        chk("t1_h_gnt", 32'(h_gnt_o), 32'h1);
        tick();
        $display("t1 request accepted");
        h_req_i = 2'b00;
        m_gnt_i = 1'b0;
        m_valid_i = 1'b1;
        m_rdata_i = 32'hDEAD_BEEF;
        m_err_i = 1'b1;
        settle();
        chk("t1_h_valid", 32'(h_valid_o), 32'h1);
        chk("t1_h_rdata", h_rdata_o, 32'hDEAD_BEEF);
        chk("t1_h_err", 32'(h_err_o), 32'h1);
        chk("t1_unexp", 32'(unexp_rsp_o), 32'h0);
        tick();
        $display("t1 response routed");
        m_err_i = 1'b0;

        // Test 2/5: both requesting; rr pointer is 1 after host 0 was served
        h_h_setup();
        m_valid_i = 1'b0;
        h_req_i = 2'b11;
        m_gnt_i = 1'b1;
        settle();
        chk("t2c1_h_gnt", 32'(h_gnt_o), 32'h2);
        chk("t2c1_m_addr", m_addr_o, 32'h0000_2000);
        tick();
        $display("t2 cycle 1");
        m_valid_i = 1'b1;
        m_rdata_i = 32'h1111_1111;
        settle();
        chk("t2c2_h_gnt", 32'(h_gnt_o), 32'h1);
        chk("t2c2_m_addr", m_addr_o, 32'h0000_1000);
        chk("t2c2_h_valid", 32'(h_valid_o), 32'h2);
        tick();
        $display("t2 cycle 2 push+pop at count 1");
        settle();
        chk("t2c3_h_gnt", 32'(h_gnt_o), 32'h2);
        chk("t2c3_h_valid", 32'(h_valid_o), 32'h1);
        tick();
        $display("t2 cycle 3");
        settle();
        chk("t2c4_h_gnt", 32'(h_gnt_o), 32'h1);
        chk("t2c4_h_valid", 32'(h_valid_o), 32'h2);
        tick();
        $display("t2 cycle 4");
        h_req_i = 2'b00;
        m_gnt_i = 1'b0;
        settle();
        chk("t2c5_m_req", 32'(m_req_o), 32'h0);
        chk("t2c5_h_valid", 32'(h_valid_o), 32'h1);
        tick();
        $display("t2 drained");
        m_valid_i = 1'b0;

        // Test 3: lock holds host 0 while gnt is low, despite rr favouring host 1
        h_addr_i[31:0] = 32'h0000_3000;
        h_addr_i[63:32] = 32'h0000_4000;
        h_req_i = 2'b01;
        m_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t3_wait_m_req", 32'(m_req_o), 32'h1);
            chk("t3_wait_h_gnt", 32'(h_gnt_o), 32'h0);
            chk("t3_wait_m_addr", m_addr_o, 32'h0000_3000);
            tick();
            $display("t3 stall cycle %0d", c);
        end
        h_req_i = 2'b11;
        settle();
        chk("t3_locked_m_addr", m_addr_o, 32'h0000_3000);
        chk("t3_locked_h_gnt", 32'(h_gnt_o), 32'h0);
        tick();
        $display("t3 second requester raised");
        m_gnt_i = 1'b1;
        settle();
        chk("t3_gnt_h_gnt", 32'(h_gnt_o), 32'h1);
        chk("t3_gnt_m_addr", m_addr_o, 32'h0000_3000);
        tick();
        $display("t3 locked request granted");
        h_req_i = 2'b00;
        m_gnt_i = 1'b0;
        m_valid_i = 1'b1;
        settle();
        chk("t3_h_valid", 32'(h_valid_o), 32'h1);
        tick();
        $display("t3 response routed");
        m_valid_i = 1'b0;

        // Test 4: fill the FIFO (rr pointer is 1)
        h_req_i = 2'b11;
        m_gnt_i = 1'b1;
        settle();
        chk("t4c1_h_gnt", 32'(h_gnt_o), 32'h2);
        tick();
        settle();
        chk("t4c2_h_gnt", 32'(h_gnt_o), 32'h1);
        tick();
        $display("t4 two accepts");
        m_valid_i = 1'b1;
        settle();
        chk("t4_full_m_req", 32'(m_req_o), 32'h0);
        chk("t4_full_h_gnt", 32'(h_gnt_o), 32'h0);
        chk("t4_full_h_valid", 32'(h_valid_o), 32'h2);
        tick();
        $display("t4 full, one response");
        m_valid_i = 1'b0;
        settle();
        chk("t4_reopen_m_req", 32'(m_req_o), 32'h1);
        chk("t4_reopen_h_gnt", 32'(h_gnt_o), 32'h2);
        tick();
        $display("t4 reopened, full again");

        // Test 6: reset with count=2, then an unexpected response
        h_req_i = 2'b00;
        m_gnt_i = 1'b0;
        rst_ni = 1'b0;
        settle();
        chk("t6_rst_m_req", 32'(m_req_o), 32'h0);
        tick();
        $display("t6 reset with outstanding requests");
        rst_ni = 1'b1;
        h_req_i = 2'b01;
        settle();
        chk("t6_after_rst_m_req", 32'(m_req_o), 32'h1);
        h_req_i = 2'b00;
        m_valid_i = 1'b1;
        settle();
        chk("t6_idle_m_req", 32'(m_req_o), 32'h0);
        chk("t6_unexp", 32'(unexp_rsp_o), 32'h1);
        chk("t6_unexp_h_valid", 32'(h_valid_o), 32'h0);
        tick();
        $display("t6 unexpected response");
        m_valid_i = 1'b0;
        settle();
        chk("t6_unexp_clear", 32'(unexp_rsp_o), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic h_h_setup();
        h_addr_i[31:0]  = 32'h0000_1000;
        h_addr_i[63:32] = 32'h0000_2000;
        h_we_i          = 2'b00;
    endtask

endmodule
